// File: rtl/step_burst_sequencer.sv
// Step-pulse burst sequencer: synchronized start/stop keys drive a
// fixed-width, fixed-rate burst of N step pulses with clean abort.
module step_burst_sequencer #(
    parameter int          CW         = 32,
    parameter int          NW         = 16,
    parameter int unsigned DEF_PERIOD = 2000,
    parameter int unsigned DEF_HIGH   = 500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_n,
    input  logic          stop_n,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_high,
    input  logic [NW-1:0] cfg_steps,
    input  logic          cfg_dir,
    output logic          step,
    output logic          dir,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [NW-1:0] steps_left,
    output logic [1:0]    state_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t state, state_n;

    logic start_s1, start_s2, start_h;
    logic stop_s1, stop_s2, stop_h;
    logic start_ev, stop_ev;

    logic [CW-1:0] period_r, high_r;
    logic [NW-1:0] steps_r;
    logic          dir_cfg_r;

    logic [CW-1:0] phase, phase_n, phase_inc;
    logic [NW-1:0] left_r, left_n;
    logic          step_r, step_n;
    logic          dir_r, dir_n;
    logic          err_r, err_n;
    logic          cfg_load;
    logic          cfg_ok;
    logic          phase_last, high_last;

    // Key synchronizers; the history flop turns a held key into one event.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_s1 <= 1'b1;
            start_s2 <= 1'b1;
            start_h  <= 1'b1;
            stop_s1  <= 1'b1;
            stop_s2  <= 1'b1;
            stop_h   <= 1'b1;
        end else begin
            start_s1 <= start_n;
            start_s2 <= start_s1;
            start_h  <= start_s2;
            stop_s1  <= stop_n;
            stop_s2  <= stop_s1;
            stop_h   <= stop_s2;
        end
    end

    assign start_ev = start_h & ~start_s2;
    assign stop_ev  = stop_h & ~stop_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_r  <= CW'(DEF_PERIOD);
            high_r    <= CW'(DEF_HIGH);
            steps_r   <= '0;
            dir_cfg_r <= 1'b0;
        end else if (cfg_load) begin
            period_r  <= cfg_period;
            high_r    <= cfg_high;
            steps_r   <= cfg_steps;
            dir_cfg_r <= cfg_dir;
        end
    end

    assign cfg_ok = (steps_r != '0) && (high_r != '0) && (high_r < period_r);

    assign phase_last = (phase == period_r - CW'(1));
    assign high_last  = (phase == high_r - CW'(1));
    assign phase_inc  = phase_last ? '0 : phase + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            phase  <= '0;
            left_r <= '0;
            step_r <= 1'b0;
            dir_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            left_r <= left_n;
            step_r <= step_n;
            dir_r  <= dir_n;
            err_r  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        left_n   = left_r;
        step_n   = step_r;
        dir_n    = dir_r;
        err_n    = err_r;
        cfg_load = 1'b0;

        unique case (state)
            S_IDLE: begin
                cfg_load = cfg_we;
                if (cfg_we) begin
                    err_n = 1'b0;
                end
                // A simultaneous stop cancels the start.
                if (start_ev && !stop_ev) begin
                    if (cfg_ok) begin
                        state_n = S_RUN;
                        phase_n = '0;
                        left_n  = steps_r;
                        dir_n   = dir_cfg_r;
                        err_n   = 1'b0;
                        step_n  = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (stop_ev) begin
                    // A pulse ending this cycle completes without a STOP visit.
                    if (step_r && !high_last) begin
                        state_n = S_STOP;
                        phase_n = phase_inc;
                        step_n  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        phase_n = '0;
                        step_n  = 1'b0;
                    end
                end else begin
                    phase_n = phase_inc;
                    step_n  = (phase_inc < high_r);
                    if (phase_last) begin
                        left_n = (left_r != '0) ? left_r - NW'(1) : '0;
                        if (left_r <= NW'(1)) begin
                            state_n = S_DONE;
                            phase_n = '0;
                            step_n  = 1'b0;
                        end
                    end
                end
            end

            S_STOP: begin
                phase_n = phase_inc;
                if (high_last) begin
                    state_n = S_IDLE;
                    phase_n = '0;
                    step_n  = 1'b0;
                end else begin
                    step_n = 1'b1;
                end
            end

            S_DONE: begin
                cfg_load = cfg_we;
                if (cfg_we) begin
                    err_n = 1'b0;
                end
                state_n = S_IDLE;
            end
        endcase
    end

    assign step       = step_r;
    assign dir        = dir_r;
    assign busy       = (state == S_RUN) || (state == S_STOP);
    assign done       = (state == S_DONE);
    assign err        = err_r;
    assign steps_left = left_r;
    assign state_code = state;

endmodule

// File: tb/tb_step_burst_sequencer.sv
// Directed bench for step_burst_sequencer.
module tb_step_burst_sequencer;

    logic        clk;
    logic        rst;
    logic        start_n;
    logic        stop_n;
    logic        cfg_we;
    logic [31:0] cfg_period;
    logic [31:0] cfg_high;
    logic [15:0] cfg_steps;
    logic        cfg_dir;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] steps_left;
    logic [1:0]  state_code;

    int checks = 0;
    int errors = 0;

    step_burst_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start_n    (start_n),
        .stop_n     (stop_n),
        .cfg_we     (cfg_we),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_steps  (cfg_steps),
        .cfg_dir    (cfg_dir),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .steps_left (steps_left),
        .state_code (state_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_cfg(input int p, input int h, input int s, input logic d);
        @(negedge clk);
        cfg_period = 32'(p);
        cfg_high   = 32'(h);
        cfg_steps  = 16'(s);
        cfg_dir    = d;
        cfg_we     = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Returns at the first negedge where a started burst is visible.
    task automatic kick_start();
        @(negedge clk);
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({step, dir, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {step, dir, busy, done, err});
        end
        checks++;
        if (steps_left !== 16'd0) begin
            errors++;
            $display("FAIL reset_left got %0d exp 0", steps_left);
        end
        checks++;
        if (state_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got %b exp 00", state_code);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        logic        e_step;
        logic [15:0] e_left;
        do_cfg(10, 3, 4, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL norm_pre_busy got %b exp 0", busy);
        end
        kick_start();
        for (int i = 0; i < 42; i++) begin
            e_step = (i < 40) && ((i % 10) < 3);
            e_left = (i < 40) ? 16'(4 - i / 10) : 16'd0;
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL norm_step i=%0d got %b exp %b", i, step, e_step);
            end
            checks++;
            if (busy !== (i < 40)) begin
                errors++;
                $display("FAIL norm_busy i=%0d got %b exp %b", i, busy, i < 40);
            end
            checks++;
            if (steps_left !== e_left) begin
                errors++;
                $display("FAIL norm_left i=%0d got %0d exp %0d", i, steps_left, e_left);
            end
            checks++;
            if (done !== (i == 40)) begin
                errors++;
                $display("FAIL norm_done i=%0d got %b exp %b", i, done, i == 40);
            end
            checks++;
            if (state_code !== ((i < 40) ? 2'b01 : (i == 40) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL norm_state i=%0d got %b", i, state_code);
            end
            if (i < 40) begin
                checks++;
                if (dir !== 1'b1) begin
                    errors++;
                    $display("FAIL norm_dir i=%0d got %b exp 1", i, dir);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stop_high();
        logic e_step;
        kick_start();
        for (int i = 0; i < 18; i++) begin
            e_step = (i <= 12) && ((i % 10) < 3);
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL stoph_step i=%0d got %b exp %b", i, step, e_step);
            end
            checks++;
            if (busy !== (i <= 12)) begin
                errors++;
                $display("FAIL stoph_busy i=%0d got %b exp %b", i, busy, i <= 12);
            end
            checks++;
            if (state_code !== ((i <= 11) ? 2'b01 : (i == 12) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL stoph_state i=%0d got %b", i, state_code);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL stoph_done i=%0d got %b exp 0", i, done);
            end
            if (i >= 10) begin
                checks++;
                if (steps_left !== 16'd3) begin
                    errors++;
                    $display("FAIL stoph_left i=%0d got %0d exp 3", i, steps_left);
                end
            end
            if (i == 9) stop_n = 1'b0;
            if (i == 10) stop_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_stop_low();
        kick_start();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (step !== (i < 3)) begin
                errors++;
                $display("FAIL stopl_step i=%0d got %b exp %b", i, step, i < 3);
            end
            checks++;
            if (busy !== (i <= 5)) begin
                errors++;
                $display("FAIL stopl_busy i=%0d got %b exp %b", i, busy, i <= 5);
            end
            checks++;
            if (steps_left !== 16'd4) begin
                errors++;
                $display("FAIL stopl_left i=%0d got %0d exp 4", i, steps_left);
            end
            if (i == 3) stop_n = 1'b0;
            if (i == 4) stop_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_bad_cfg();
        do_cfg(10, 10, 4, 1'b0);
        kick_start();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({err, busy, step} !== 3'b100) begin
                errors++;
                $display("FAIL bad_flags i=%0d got %b exp 100", i, {err, busy, step});
            end
            checks++;
            if (state_code !== 2'b00) begin
                errors++;
                $display("FAIL bad_state i=%0d got %b exp 00", i, state_code);
            end
            @(negedge clk);
        end
        do_cfg(10, 3, 4, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_clear got %b exp 0", err);
        end
    endtask

    task automatic test_cfg_lock();
        do_cfg(10, 3, 2, 1'b0);
        for (int b = 0; b < 2; b++) begin
            kick_start();
            for (int i = 0; i < 21; i++) begin
                checks++;
                if (step !== ((i < 20) && ((i % 10) < 3))) begin
                    errors++;
                    $display("FAIL lock_step b=%0d i=%0d got %b", b, i, step);
                end
                checks++;
                if (busy !== (i < 20)) begin
                    errors++;
                    $display("FAIL lock_busy b=%0d i=%0d got %b", b, i, busy);
                end
                checks++;
                if (done !== (i == 20)) begin
                    errors++;
                    $display("FAIL lock_done b=%0d i=%0d got %b", b, i, done);
                end
                if (i < 20) begin
                    checks++;
                    if (dir !== 1'b0) begin
                        errors++;
                        $display("FAIL lock_dir b=%0d i=%0d got %b exp 0", b, i, dir);
                    end
                end
                if (b == 0 && i == 2) begin
                    cfg_period = 32'd4;
                    cfg_high   = 32'd1;
                    cfg_steps  = 16'd5;
                    cfg_dir    = 1'b1;
                    cfg_we     = 1'b1;
                end
                if (i == 3) cfg_we = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_cfg(10, 3, 4, 1'b1);
        kick_start();
        repeat (11) @(negedge clk);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre_step got %b exp 1", step);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({step, dir, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_flags got %b exp 00000", {step, dir, busy, done, err});
        end
        checks++;
        if (steps_left !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_left got %0d exp 0", steps_left);
        end
        rst = 1'b0;
        kick_start();
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_defcfg got %b exp 10", {err, busy});
        end
    endtask

    task automatic test_simultaneous();
        do_cfg(10, 3, 4, 1'b0);
        @(negedge clk);
        start_n = 1'b0;
        stop_n  = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
        stop_n  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, err, step} !== 3'b000) begin
                errors++;
                $display("FAIL simul i=%0d got %b exp 000", i, {busy, err, step});
            end
        end
    endtask

    task automatic test_held_key();
        do_cfg(10, 3, 1, 1'b1);
        @(negedge clk);
        start_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (busy !== (i < 10)) begin
                errors++;
                $display("FAIL held_busy i=%0d got %b exp %b", i, busy, i < 10);
            end
            checks++;
            if (done !== (i == 10)) begin
                errors++;
                $display("FAIL held_done i=%0d got %b exp %b", i, done, i == 10);
            end
            @(negedge clk);
        end
        start_n = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        start_n    = 1'b1;
        stop_n     = 1'b1;
        cfg_we     = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_steps  = '0;
        cfg_dir    = 1'b0;
        test_reset();
        test_normal();
        test_stop_high();
        test_stop_low();
        test_bad_cfg();
        test_cfg_lock();
        test_reset_mid();
        test_simultaneous();
        test_held_key();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_burst_sequencer.md
# step_burst_sequencer

Sequencer for the step-pulse datapath. It takes active-low start/stop keys and a register-programmed burst description (period, high time, pulse count, direction). It emits exactly N fixed-width step pulses at the programmed rate, then signals completion. It sits between the board keys and the stepper driver pins and replaces free-running pulse generation with a controlled, abortable burst.

## Interface
- CW, 32, width of period/high-time counters
- NW, 16, width of step-count registers
- DEF_PERIOD, 2000, period register reset value (clk cycles)
- DEF_HIGH, 500, high-time register reset value (clk cycles)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_n  in  1  start key, active-low, asynchronous
- stop_n  in  1  stop key, active-low, asynchronous
- cfg_we  in  1  load cfg_* into config registers
- cfg_period  in  CW  pulse period in cycles
- cfg_high  in  CW  step high time in cycles
- cfg_steps  in  NW  pulses per burst
- cfg_dir  in  1  direction for next burst
- step  out  1  step pulse, registered
- dir  out  1  latched direction, registered
- busy  out  1  burst in progress (RUN or STOP)
- done  out  1  one-cycle pulse, burst completed normally
- err  out  1  sticky: start rejected due to bad config
- steps_left  out  NW  pulses not yet completed
- state_code  out  2  00 IDLE, 01 RUN, 10 STOP, 11 DONE (LED drive)

## Operation
- Keys: each key passes through a 2-flop synchronizer plus a history flop. An event is a falling edge of the synchronized level; a held key produces one event only.
- Config registers reset to DEF_PERIOD, DEF_HIGH, steps=0, dir=0. cfg_we loads them in IDLE and DONE only; it is ignored while busy. cfg_we also clears err.
- IDLE, start event: config is valid iff steps≠0, high≠0 and high<period.
  - Valid: go to RUN. Load phase=0, steps_left=steps, dir=cfg dir register, clear err.
  - Invalid: set err and stay in IDLE.
- RUN: phase counts 0..period-1 and wraps. step=1 while phase<high. At phase==period-1, steps_left decrements. When it reaches 0, go to DONE.
- RUN, stop event:
  - step currently 1: go to STOP. The pulse is never truncated.
  - step currently 0: go to IDLE directly.
- STOP: phase keeps counting. At phase==high-1 (last high cycle), go to IDLE. steps_left is frozen at its value when stop arrived.
- DONE: lasts one cycle with done=1, then IDLE.
- Start events in RUN, STOP and DONE are ignored. A stop event in IDLE or DONE is ignored.
- Start and stop events in the same cycle in IDLE: stop wins and no burst starts.
- dir is constant while busy.

## Timing
- Reset values: step=0, dir=0, busy=0, done=0, err=0, steps_left=0, state_code=00, phase=0, sync flops=1 (key released).
- Key latency: start_n sampled low at edge k. busy=1 and step=1 are first visible after edge k+2.
- Stop latency: stop_n sampled low at edge k takes effect at edge k+2.
- Pulse shape: each pulse is exactly high cycles of 1, then period-high cycles of 0.
- Normal burst:
  - busy is high for exactly steps×period cycles.
  - done rises on the cycle after the last low cycle; busy is 0 in that same cycle.
  - steps_left reads 0 while done=1.
- rst mid-burst: at the next edge all outputs return to reset values, including step=0 even mid-pulse, and the config registers return to their defaults.
- Arithmetic: phase is an unsigned CW-bit counter and never exceeds period-1. steps_left never underflows.

## Test plan
- Normal burst: period=10, high=3, steps=4, start -> 4 pulses, each 3 high / 7 low; busy=40 cycles; steps_left 4→3→2→1→0; done=1 for 1 cycle; state_code 01→11→00.
- Stop during high: same config, stop event arriving at phase=1 of pulse 2 -> step stays high through phase 2, then IDLE; steps_left=3; no done.
- Stop during low: stop at phase=5 -> IDLE 2 edges later; step stays 0; busy drops.
- Bad config: high=10, period=10, start -> err=1, step never rises, state 00; a subsequent cfg_we clears err.
- Config lock: cfg_we with period=4 mid-burst -> burst keeps period=10; the next burst uses period=10 (the write was dropped).
- Reset and simultaneous events: rst during a high phase -> step=0 and steps_left=0 at the next edge. Start and stop events in the same cycle while in IDLE -> no burst, busy=0.
